// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and defaults for the memory controller
// Contents: FSM state enum, default DEPTH / WAIT_CYCLES, wait-counter width.
package mem_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;
    localparam int DEPTH_DEF       = 64;
    localparam int WAIT_CYCLES_DEF = 1;
    localparam int CNT_W           = 4;
endpackage

// File: rtl/mem_ctrl_wcnt.sv
// mem_ctrl_wcnt: loadable down-counter with a zero flag for RAM wait states
// Ports: clk_i, rst_ni (async active-low), load_i/load_val_i load the count,
//        dec_i decrements (saturating at 0), zero_o = count is 0 after this edge.
module mem_ctrl_wcnt
    import mem_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    // flag looks at the next value so the FSM can leave WAIT on the edge the count hits 0
    assign zero_o = cnt_d == '0;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding core-to-SRAM access controller with wait states
// Ports: clk_i, rst_ni (async active-low); req_* core request (valid/ready/we/adr/wdata);
//        rsp_* response (valid/ready/rdata/err); ram_* SRAM port (en/we/adr/wdata/rdata,
//        rdata registered one cycle after en).
// Macro MEM_CTRL_ALIGN_CHECK_EN: misaligned byte addresses take the error path.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter  int DEPTH       = DEPTH_DEF,
    parameter  int WAIT_CYCLES = WAIT_CYCLES_DEF,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [31:0]   req_adr_i,
    input  logic [31:0]   req_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_rdata_o,
    output logic          rsp_err_o,
    output logic          ram_en_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_adr_o,
    output logic [31:0]   ram_wdata_o,
    input  logic [31:0]   ram_rdata_i
);
    state_e        state_q;
    logic          req_ready_q, rsp_valid_q, rsp_err_q, we_q, fresh_q;
    logic          ram_en_q, ram_we_q, bad, zero;
    logic [31:0]   rsp_rdata_q, ram_wdata_q;
    logic [AW-1:0] ram_adr_q;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    assign bad = req_adr_i[31:2] >= 30'(DEPTH) || req_adr_i[1:0] != 2'b00;
`else
    logic unused_adr;
    assign unused_adr = ^req_adr_i[1:0];
    assign bad = req_adr_i[31:2] >= 30'(DEPTH);
`endif
    mem_ctrl_wcnt u_wcnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (state_q == ACCESS),
        .dec_i      (state_q == WAIT),
        .load_val_i (CNT_W'(WAIT_CYCLES)),
        .zero_o     (zero)
    );
    // With no wait states the RAM data only appears in the first RESP cycle, so it is
    // passed through then (fresh_q) and held in rsp_rdata_q from the next cycle on.
    assign rsp_rdata_o = fresh_q ? ram_rdata_i : rsp_rdata_q;
    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign ram_en_o    = ram_en_q;
    assign ram_we_o    = ram_we_q;
    assign ram_adr_o   = ram_adr_q;
    assign ram_wdata_o = ram_wdata_q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            fresh_q     <= 1'b0;
            we_q        <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_adr_q   <= '0;
            ram_wdata_q <= '0;
        end else begin
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            case (state_q)
                IDLE: if (req_valid_i) begin
                    req_ready_q <= 1'b0;
                    we_q        <= req_we_i;
                    if (bad) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        state_q     <= ACCESS;
                        ram_en_q    <= 1'b1;
                        ram_we_q    <= req_we_i;
                        ram_adr_q   <= req_adr_i[AW+1:2];
                        ram_wdata_q <= req_wdata_i;
                    end
                end
                ACCESS: if (WAIT_CYCLES == 0) begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= '0;
                    fresh_q     <= ~we_q;
                end else state_q <= WAIT;
                WAIT: if (zero) begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= we_q ? '0 : ram_rdata_i;
                end
                RESP: begin
                    fresh_q <= 1'b0;
                    if (fresh_q) rsp_rdata_q <= ram_rdata_i;
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl (WAIT_CYCLES=1 and WAIT_CYCLES=0 instances)
module tb_mem_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [31:0] req_adr = '0, req_wdata = '0;
    logic        rr1, rv1, re1, ren1, rwe1, rr0, rv0, re0, ren0, rwe0;
    logic [31:0] rd1, rwd1, rrd1, rd0, rwd0, rrd0;
    logic [5:0]  radr1, radr0;
    logic [31:0] mem1 [64];
    logic [31:0] mem0 [64];
    int          en1 = 0, en0 = 0;
    int          n_run = 0, n_fail = 0;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
    } vec_t;
    vec_t v [12];

    always #5 clk = ~clk;

    mem_ctrl #(.DEPTH(64), .WAIT_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(rr1),
        .req_we_i(req_we), .req_adr_i(req_adr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rv1), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd1), .rsp_err_o(re1),
        .ram_en_o(ren1), .ram_we_o(rwe1), .ram_adr_o(radr1), .ram_wdata_o(rwd1),
        .ram_rdata_i(rrd1));

    mem_ctrl #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(rr0),
        .req_we_i(req_we), .req_adr_i(req_adr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rv0), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd0), .rsp_err_o(re0),
        .ram_en_o(ren0), .ram_we_o(rwe0), .ram_adr_o(radr0), .ram_wdata_o(rwd0),
        .ram_rdata_i(rrd0));

    // synchronous RAM models: read data registered one cycle after en
    always @(posedge clk) if (ren1) begin
        if (rwe1) mem1[radr1] <= rwd1; else rrd1 <= mem1[radr1];
        en1 <= en1 + 1;
    end
    always @(posedge clk) if (ren0) begin
        if (rwe0) mem0[radr0] <= rwd0; else rrd0 <= mem0[radr0];
        en0 <= en0 + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_rst(input string nm);
        chk({nm, "_ctl"}, {58'd0, rr1, rv1, re1, ren1, rwe1, rr0}, {58'd0, 6'b100001});
        chk({nm, "_adr"}, {52'd0, radr1, radr0}, 64'd0);
        chk({nm, "_dat"}, {rd1, rwd1}, 64'd0);
        chk({nm, "_v0"}, {60'd0, rv0, re0, ren0, rwe0}, 64'd0);
    endtask

    // called at a negedge with both DUTs idle; returns at the negedge of cycle T+1
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] wd);
        chk("ready", {62'd0, rr1, rr0}, 64'd3);
        req_valid = 1'b1; req_we = we; req_adr = adr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic xfer(input int i);
        int          l1, l0, b1, b0;
        logic [31:0] d1, d0;
        logic        e1, e0;
        l1 = 0; l0 = 0; d1 = '0; d0 = '0; e1 = 1'b0; e0 = 1'b0; b1 = en1; b0 = en0;
        issue(v[i].we, v[i].adr, v[i].wd);
        for (int k = 1; k <= 16; k++) begin
            if (rv0 && l0 == 0) begin l0 = k; d0 = rd0; e0 = re0; end
            if (rv1) begin l1 = k; d1 = rd1; e1 = re1; break; end
            @(negedge clk);
        end
        chk($sformatf("v%0d_lat1", i), 64'(l1), v[i].err ? 64'd1 : 64'd3);
        chk($sformatf("v%0d_rsp1", i), {31'd0, e1, d1}, {31'd0, v[i].err, v[i].rd});
        chk($sformatf("v%0d_lat0", i), 64'(l0), v[i].err ? 64'd1 : 64'd2);
        chk($sformatf("v%0d_rsp0", i), {31'd0, e0, d0}, {31'd0, v[i].err, v[i].rd});
        chk($sformatf("v%0d_en", i), {32'(en1 - b1), 32'(en0 - b0)},
            v[i].err ? 64'd0 : {32'd1, 32'd1});
        @(negedge clk);
        chk($sformatf("v%0d_idle", i), {60'd0, rr1, rv1, rr0, rv0}, 64'b1010);
    endtask

    // reset during ACCESS (at=1) or WAIT (at=2) of a transfer
    task automatic abort(input logic we, input logic [31:0] adr, input logic [31:0] wd, input int at);
        issue(we, adr, wd);
        if (at == 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_rst($sformatf("abort%0d", at));
        repeat (2) begin
            @(negedge clk);
            chk("abort_novalid", {62'd0, rv1, rr1}, 64'b01);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_release", {60'd0, rr1, rv1, rr0, rv0}, 64'b1010);
    endtask

    initial begin
        v[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0};
        v[1]  = '{1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
        v[2]  = '{1'b1, 32'hFC,       32'h12345678, 1'b0, 32'h0};
        v[3]  = '{1'b0, 32'hFC,       32'h0,        1'b0, 32'h12345678};
        v[4]  = '{1'b0, 32'h100,      32'h0,        1'b1, 32'h0};
        v[5]  = '{1'b1, 32'h0,        32'hA5A5A5A5, 1'b0, 32'h0};
        v[6]  = '{1'b1, 32'h100,      32'h0000AAAA, 1'b1, 32'h0};
        v[7]  = '{1'b0, 32'hFFFFFFF0, 32'h0,        1'b1, 32'h0};
        v[8]  = '{1'b0, 32'h0,        32'h0,        1'b0, 32'hA5A5A5A5};
`ifdef MEM_CTRL_ALIGN_CHECK_EN
        v[9]  = '{1'b0, 32'h12,       32'h0,        1'b1, 32'h0};
`else
        v[9]  = '{1'b0, 32'h12,       32'h0,        1'b0, 32'hDEADBEEF};
`endif
        v[10] = '{1'b1, 32'h24,       32'h11111111, 1'b0, 32'h0};
        v[11] = '{1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};

        repeat (2) @(negedge clk);
        chk_rst("por");
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) xfer(i);

        // back-pressure: response held for 5 cycles, then released
        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0);
        for (int k = 0; k < 16 && !rv1; k++) @(negedge clk);
        chk("bp_first", {rv1, re1, rd1}, {1'b1, 1'b0, 32'hDEADBEEF});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold1", {rr1, rv1, re1, rd1}, {3'b010, 32'hDEADBEEF});
            chk("bp_hold0", {rr0, rv0, re0, rd0}, {3'b010, 32'hDEADBEEF});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {60'd0, rr1, rv1, rr0, rv0}, 64'b1010);

        // reset mid-WAIT of a read, and write commit depends on ACCESS edge
        abort(1'b0, 32'h10, 32'h0, 2);
        abort(1'b1, 32'h20, 32'hCAFEF00D, 2);
        abort(1'b1, 32'h24, 32'h22222222, 1);
        v[0] = '{1'b0, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D};
        v[1] = '{1'b0, 32'h24, 32'h0, 1'b0, 32'h11111111};
        xfer(0);
        xfer(1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set the number of 32-bit RAM words addressed (power of two, 4..1024).
REQ-002 Parameter WAIT_CYCLES, default 1, SHALL set the extra RAM access wait states (0..15).
REQ-003 Derived localparam AW = log2(DEPTH) SHALL set the RAM address width.
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  core access request.
REQ-007 req_ready  out  1  controller can accept a request this cycle.
REQ-008 req_we  in  1  request is a write (1) or read (0).
REQ-009 req_adr  in  32  byte address from the core.
REQ-010 req_wdata  in  32  write data.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  core accepts the response.
REQ-013 rsp_rdata  out  32  read data; 0 for writes and errors.
REQ-014 rsp_err  out  1  access faulted; no RAM activity occurred.
REQ-015 ram_en, ram_we  out  1 each  RAM strobe and write enable.
REQ-016 ram_adr  out  AW  word address; ram_wdata  out  32; ram_rdata  in  32, registered one cycle after ram_en.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, WAIT and RESP.
REQ-018 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-019 Handshake: req_valid & req_ready in cycle T SHALL latch req_we, req_adr and req_wdata.
REQ-020 If req_adr[31:2] >= DEPTH, the FSM SHALL go directly to RESP with rsp_err=1 and rsp_rdata=0, and SHALL NOT assert ram_en.
REQ-021 Otherwise the FSM SHALL enter ACCESS at T+1 and drive ram_en=1, ram_we=latched we, ram_adr=adr[AW+1:2] and ram_wdata=latched data for exactly that one cycle.
REQ-022 From ACCESS, the FSM SHALL enter WAIT with a counter loaded with WAIT_CYCLES, or enter RESP directly when WAIT_CYCLES=0.
REQ-023 WAIT SHALL decrement the counter each cycle and exit to RESP when the counter reaches 0.
REQ-024 A read SHALL capture ram_rdata into rsp_rdata on entry to RESP.
REQ-025 rsp_valid SHALL first assert at T+2+WAIT_CYCLES for RAM accesses and at T+1 for errors.
REQ-026 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1.
REQ-027 When rsp_ready=1 in RESP, the FSM SHALL return to IDLE the next cycle; back-to-back accesses are therefore spaced by at least WAIT_CYCLES+3 cycles.
REQ-028 If rsp_ready is already high when RESP is entered, the response SHALL complete in one cycle.
REQ-029 Outside ACCESS, ram_en and ram_we SHALL be 0.

Reset
REQ-030 While reset=0, the controller SHALL force state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, ram_en=0, ram_we=0, ram_adr=0, ram_wdata=0 and counter=0, asynchronously.
REQ-031 A reset asserted mid-access SHALL abort the access with no response; a write is committed only if its ACCESS edge preceded the reset.
REQ-032 The first request SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-033 With MEM_CTRL_ALIGN_CHECK_EN defined, req_adr[1:0] != 0 SHALL take the error path of REQ-020.
REQ-034 Without MEM_CTRL_ALIGN_CHECK_EN, req_adr[1:0] SHALL be ignored.

Structure
REQ-035 Package mem_ctrl_pkg SHALL hold the state enum typedef, the default DEPTH and WAIT_CYCLES, and the counter width constant (4).
REQ-036 One sub-module, mem_ctrl_wcnt (a loadable down-counter with a zero flag), SHALL implement the wait counter.

Verification
REQ-037 Read after write: write 0xDEADBEEF to 0x10, then read 0x10 with WAIT_CYCLES=1 and rsp_ready=1 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid at T+3.
REQ-038 Range error: DEPTH=64, read 0x100 -> rsp_valid at T+1, rsp_err=1, rsp_rdata=0, ram_en never asserted.
REQ-039 Back-pressure: hold rsp_ready=0 for 5 cycles -> rsp_* stable and req_ready=0 throughout; release -> IDLE next cycle.
REQ-040 Alignment: read 0x12 -> rsp_err=1 with MEM_CTRL_ALIGN_CHECK_EN, reads word 4 without it.
REQ-041 Reset mid-WAIT: assert reset during WAIT of a read -> outputs at reset values immediately, no rsp_valid, req_ready=1 after release.
REQ-042 WAIT_CYCLES=0: a read response arrives at T+2, and two sequential requests are each accepted cleanly.
